// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states and default line parameters.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int DEF_CLKS_PER_BIT = 432;
    localparam int DEF_DATA_BITS    = 8;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO between the host push side and the serialiser.
// Latency: a push is visible on rd_dat / empty one cycle later.
// Backpressure: full must gate push upstream; pop only when not empty.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_pin,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_dat,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    assign rd_dat = mem[rd_ptr];
    assign full   = (count == CW'(DEPTH));
    assign empty  = (count == '0);

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (reset_pin) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_dat;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: FIFO-fed 8N1/8N2 serialiser, LSB first, idle-high line.
// Latency: push at edge k -> pop at k+1 -> start bit on tx from k+2.
// Backpressure: tx_ready drops while the FIFO is full; frames chain back-to-back when queued.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int  CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int  DATA_BITS    = DEF_DATA_BITS,
    parameter int  STOP_BITS    = 1,
    parameter int  FIFO_DEPTH   = 4,
    localparam int CW           = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset_pin,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_busy,
    output logic [CW-1:0]        fifo_count
);

    localparam int BW    = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    uart_state_t          state;
    logic [BW-1:0]        baud_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shifter;

    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] fifo_dat;
    logic                 baud_last;
    logic                 stop_last;

    assign tx_ready  = !fifo_full;
    assign fifo_push = tx_valid && tx_ready;
    assign baud_last = (baud_cnt == BW'(CLKS_PER_BIT - 1));
    assign stop_last = (state == STOP) && baud_last && (bit_cnt == BIT_W'(STOP_BITS - 1));
    assign fifo_pop  = !fifo_empty && ((state == IDLE) || stop_last);

    uart_tx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_pin (reset_pin),
        .push      (fifo_push),
        .wr_dat    (tx_data),
        .pop       (fifo_pop),
        .rd_dat    (fifo_dat),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (reset_pin) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shifter  <= '0;
            tx       <= 1'b1;
            tx_busy  <= 1'b0;
        end else begin
            // tx and tx_busy trail the state by one cycle, so busy drops exactly when the last stop bit ends.
            tx       <= (state == START) ? 1'b0 : (state == DATA) ? shifter[0] : 1'b1;
            tx_busy  <= (state != IDLE) || !fifo_empty;
            baud_cnt <= (state == IDLE || baud_last) ? '0 : baud_cnt + BW'(1);

            case (state)
                IDLE: begin
                    if (fifo_pop) begin
                        shifter <= fifo_dat;
                        bit_cnt <= '0;
                        state   <= START;
                    end
                end
                START: begin
                    if (baud_last) begin
                        bit_cnt <= '0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (baud_last) begin
                        shifter <= shifter >> 1;
                        if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
                            bit_cnt <= '0;
                            state   <= STOP;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end
                    end
                end
                STOP: begin
                    if (stop_last) begin
                        bit_cnt <= '0;
                        if (fifo_pop) begin
                            shifter <= fifo_dat;
                            state   <= START;
                        end else begin
                            state   <= IDLE;
                        end
                    end else if (baud_last) begin
                        bit_cnt <= bit_cnt + BIT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: a 432-clk/bit 8N1 instance and a 4-clk/bit 8N2 instance,
// checked against expected frame bit patterns and an independent mid-bit line decoder.
module tb_uart_tx_buffered;

    localparam int CPB = 432;

    logic       clk;
    logic       reset_pin;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx;
    logic       tx_busy;
    logic [2:0] fifo_count;

    logic [7:0] tx_data_f;
    logic       tx_valid_f;
    logic       tx_ready_f;
    logic       tx_f;
    logic       tx_busy_f;
    logic [2:0] fifo_count_f;

    int checks = 0;
    int passes = 0;
    int cyc    = 0;
    int rx_q[$];

    uart_tx_buffered #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .reset_pin  (reset_pin),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx         (tx),
        .tx_busy    (tx_busy),
        .fifo_count (fifo_count)
    );

    uart_tx_buffered #(.CLKS_PER_BIT(4), .DATA_BITS(8), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_f (
        .clk        (clk),
        .reset_pin  (reset_pin),
        .tx_data    (tx_data_f),
        .tx_valid   (tx_valid_f),
        .tx_ready   (tx_ready_f),
        .tx         (tx_f),
        .tx_busy    (tx_busy_f),
        .fifo_count (fifo_count_f)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Line decoder for the slow instance: finds a start bit, samples each bit mid-way.
    initial begin
        logic [7:0] mb;
        forever begin
            @(posedge clk);
            #1;
            if (tx === 1'b0) begin
                mb = 8'h00;
                repeat (CPB / 2) @(posedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(posedge clk);
                    #1;
                    mb[i] = tx;
                end
                repeat (CPB) @(posedge clk);
                #1;
                rx_q.push_back((tx === 1'b1) ? int'(mb) : -1);
            end
        end
    end

    task automatic push_slow(input logic [7:0] b);
        tx_data  = b;
        tx_valid = 1'b1;
        step(1);
        tx_valid = 1'b0;
    endtask

    // Called one cycle into the start bit; returns one cycle after the last stop bit.
    task automatic check_frame(input logic [7:0] b, input bit fast, input string tag);
        int   cpb = fast ? 4 : CPB;
        int   nb  = fast ? 11 : 10;
        int   bad;
        logic exp_bit;
        logic line;
        logic first_bad;
        for (int i = 0; i < nb; i++) begin
            exp_bit   = (i == 0) ? 1'b0 : (i <= 8) ? b[i-1] : 1'b1;
            bad       = 0;
            first_bad = exp_bit;
            for (int c = 0; c < cpb; c++) begin
                line = fast ? tx_f : tx;
                if (line !== exp_bit) begin
                    if (bad == 0) first_bad = line;
                    bad++;
                end
                if (i == nb - 1 && c == cpb - 1) begin
                    checks++;
                    if ((fast ? tx_busy_f : tx_busy) !== 1'b1)
                        $display("FAIL %s busy_last_stop: tx_busy=%b expected 1", tag, fast ? tx_busy_f : tx_busy);
                    else passes++;
                end
                step(1);
            end
            checks++;
            if (bad != 0)
                $display("FAIL %s bit%0d: %0d of %0d cycles tx=%b expected %b", tag, i, bad, cpb, first_bad, exp_bit);
            else passes++;
        end
    endtask

    task automatic test_reset;
        int bad = 0;
        reset_pin = 1'b1;
        step(1);
        checks++;
        if (tx !== 1'b1) $display("FAIL reset_first_edge: tx=%b expected 1", tx); else passes++;
        step(2);
        reset_pin = 1'b0;
        step(1);
        checks++;
        if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_ready !== 1'b1 || fifo_count !== 3'd0)
            $display("FAIL reset_state: tx=%b busy=%b ready=%b count=%0d expected 1 0 1 0", tx, tx_busy, tx_ready, fifo_count);
        else passes++;
        for (int i = 0; i < 10000; i++) begin
            if (tx !== 1'b1 || tx_f !== 1'b1 || tx_busy !== 1'b0) bad++;
            step(1);
        end
        checks++;
        if (bad != 0) $display("FAIL idle_10000: %0d bad cycles, expected 0", bad); else passes++;
    endtask

    task automatic test_single_byte;
        rx_q.delete();
        push_slow(8'h5A);
        step(1);
        checks++;
        if (tx !== 1'b1 || tx_busy !== 1'b1 || fifo_count !== 3'd0)
            $display("FAIL single_k1: tx=%b busy=%b count=%0d expected 1 1 0", tx, tx_busy, fifo_count);
        else passes++;
        step(1);
        check_frame(8'h5A, 1'b0, "single");
        checks++;
        if (tx_busy !== 1'b0 || tx !== 1'b1)
            $display("FAIL single_busy_fall: busy=%b tx=%b expected 0 1", tx_busy, tx);
        else passes++;
        checks++;
        if (rx_q.size() != 1 || rx_q[0] != 32'h5A)
            $display("FAIL single_decode: got %0d bytes first=%0d expected 1 byte 90", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : -2);
        else passes++;
    endtask

    task automatic test_back_to_back;
        rx_q.delete();
        push_slow(8'h55);
        push_slow(8'hAA);
        step(1);
        check_frame(8'h55, 1'b0, "b2b_first");
        check_frame(8'hAA, 1'b0, "b2b_second");
        checks++;
        if (tx_busy !== 1'b0) $display("FAIL b2b_busy_end: busy=%b expected 0", tx_busy); else passes++;
        checks++;
        if (rx_q.size() != 2 || rx_q[0] != 32'h55 || rx_q[1] != 32'hAA)
            $display("FAIL b2b_decode: got %0d bytes expected 85,170", rx_q.size());
        else passes++;
    endtask

    task automatic test_fifo_full;
        int p1;
        int acc;
        int guard = 0;
        rx_q.delete();
        tx_valid = 1'b1;
        for (int n = 1; n <= 5; n++) begin
            tx_data = 8'(n);
            step(1);
            if (n == 1) p1 = cyc;
        end
        tx_data = 8'd6;
        checks++;
        if (tx_ready !== 1'b0 || fifo_count !== 3'd4)
            $display("FAIL full_state: ready=%b count=%0d expected 0 4", tx_ready, fifo_count);
        else passes++;
        while (tx_ready !== 1'b1 && guard < 10000) begin
            step(1);
            guard++;
        end
        step(1);
        tx_valid = 1'b0;
        acc = cyc;
        // Byte 2 leaves on edge p1+4321; the freed slot is taken on the following edge.
        checks++;
        if (acc != p1 + 4322) $display("FAIL full_accept_edge: edge %0d expected %0d", acc - p1, 4322); else passes++;
        checks++;
        if (fifo_count !== 3'd4) $display("FAIL full_count_after: count=%0d expected 4", fifo_count); else passes++;
        guard = 0;
        while (rx_q.size() < 6 && guard < 40000) begin
            step(1);
            guard++;
        end
        checks++;
        if (rx_q.size() != 6) $display("FAIL full_frames: got %0d expected 6", rx_q.size());
        else passes++;
        for (int n = 0; n < 6 && n < rx_q.size(); n++) begin
            checks++;
            if (rx_q[n] != n + 1) $display("FAIL full_order%0d: byte=%0d expected %0d", n, rx_q[n], n + 1);
            else passes++;
        end
        step(300);
        checks++;
        if (tx_busy !== 1'b0 || fifo_count !== 3'd0)
            $display("FAIL full_drain: busy=%b count=%0d expected 0 0", tx_busy, fifo_count);
        else passes++;
    endtask

    task automatic test_reset_mid_frame;
        push_slow(8'hC3);
        push_slow(8'($urandom_range(0, 255)));
        push_slow(8'($urandom_range(0, 255)));
        checks++;
        if (fifo_count !== 3'd2) $display("FAIL midrst_queued: count=%0d expected 2", fifo_count); else passes++;
        step(4 * CPB + 100);
        checks++;
        if (tx !== 1'b0) $display("FAIL midrst_bit3: tx=%b expected 0", tx); else passes++;
        reset_pin = 1'b1;
        step(1);
        checks++;
        if (tx !== 1'b1 || tx_busy !== 1'b0 || fifo_count !== 3'd0 || tx_ready !== 1'b1)
            $display("FAIL midrst_state: tx=%b busy=%b count=%0d ready=%b expected 1 0 0 1", tx, tx_busy, fifo_count, tx_ready);
        else passes++;
        reset_pin = 1'b0;
        step(5000);
        checks++;
        if (tx !== 1'b1 || tx_busy !== 1'b0) $display("FAIL midrst_idle: tx=%b busy=%b expected 1 0", tx, tx_busy); else passes++;
        rx_q.delete();
        push_slow(8'h81);
        step(2);
        check_frame(8'h81, 1'b0, "midrst_clean");
        checks++;
        if (rx_q.size() != 1 || rx_q[0] != 32'h81)
            $display("FAIL midrst_decode: got %0d bytes expected 1 byte 129", rx_q.size());
        else passes++;
    endtask

    task automatic test_fast_two_stop;
        logic [7:0] b [3];
        tx_data_f  = 8'hFF;
        tx_valid_f = 1'b1;
        step(1);
        tx_valid_f = 1'b0;
        step(2);
        check_frame(8'hFF, 1'b1, "fast_ff");
        checks++;
        if (tx_busy_f !== 1'b0 || tx_f !== 1'b1)
            $display("FAIL fast_len44: busy=%b tx=%b expected 0 1", tx_busy_f, tx_f);
        else passes++;
        for (int r = 0; r < 5; r++) begin
            step($urandom_range(1, 20));
            for (int i = 0; i < 3; i++) b[i] = 8'($urandom_range(0, 255));
            tx_valid_f = 1'b1;
            for (int i = 0; i < 3; i++) begin
                tx_data_f = b[i];
                step(1);
            end
            tx_valid_f = 1'b0;
            for (int i = 0; i < 3; i++) check_frame(b[i], 1'b1, "fast_burst");
            checks++;
            if (tx_busy_f !== 1'b0) $display("FAIL fast_burst_end: busy=%b expected 0", tx_busy_f); else passes++;
        end
    endtask

    initial begin
        reset_pin  = 1'b1;
        tx_data    = 8'h00;
        tx_valid   = 1'b0;
        tx_data_f  = 8'h00;
        tx_valid_f = 1'b0;
        #1;
        test_reset;
        test_single_byte;
        test_back_to_back;
        test_fifo_full;
        test_reset_mid_frame;
        test_fast_two_stop;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
